// File: rtl/voice_allocator_if.sv
`default_nettype none
// ============================================================================
// Module   : voice_allocator_if
// Brief    : Note-event handshake, ADSR update and voice lookup bundle.
// Revision : 1.0
// ============================================================================
interface voice_allocator_if;
    logic       i_note_valid;
    logic       i_note_on;
    logic [6:0] i_note_num;
    logic       o_note_ready;

    logic [1:0] i_pipeline_state;
    logic       o_upd_flag;
    logic       o_upd_note_status;
    logic [7:0] o_upd_voice_index;

    logic [7:0] i_lookup_voice;
    logic [6:0] o_lookup_note;
    logic       o_lookup_active;

    modport master (
        output i_note_valid, i_note_on, i_note_num, i_pipeline_state, i_lookup_voice,
        input  o_note_ready, o_upd_flag, o_upd_note_status, o_upd_voice_index,
               o_lookup_note, o_lookup_active
    );

    modport slave (
        input  i_note_valid, i_note_on, i_note_num, i_pipeline_state, i_lookup_voice,
        output o_note_ready, o_upd_flag, o_upd_note_status, o_upd_voice_index,
               o_lookup_note, o_lookup_active
    );
endinterface
`default_nettype wire

// File: rtl/voice_allocator.sv
`default_nettype none
// ============================================================================
// Module   : voice_allocator
// Brief    : Maps note events onto voice slots and paces ADSR keystate updates.
// Revision : 1.0
// ============================================================================
module voice_allocator #(
    parameter int NUM_VOICES = 8,
    parameter int AGE_W      = 8
) (
    input  wire logic         i_clk,
    input  wire logic         i_reset_n,
    voice_allocator_if.slave  bus
);

    localparam int              IDX_W          = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [IDX_W-1:0] c_LAST_IDX    = IDX_W'(NUM_VOICES - 1);
    localparam logic [8:0]      c_NUM_VOICES_9 = 9'(NUM_VOICES);
    localparam logic [1:0]      c_PIPE_CLEAR   = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_ISSUE = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic             r_active [NUM_VOICES];
    logic [6:0]       r_note   [NUM_VOICES];
    logic [AGE_W-1:0] r_age    [NUM_VOICES];

    logic             r_note_on;
    logic [6:0]       r_note_num;
    logic [IDX_W-1:0] r_scan_idx;
    logic             r_match_found;
    logic [IDX_W-1:0] r_match_idx;
    logic             r_free_found;
    logic [IDX_W-1:0] r_free_idx;
    logic [IDX_W-1:0] r_oldest_idx;
    logic [AGE_W-1:0] r_oldest_age;
    logic             r_hold_status;
    logic [7:0]       r_hold_index;

    logic             w_ready;
    logic             w_flag;
    logic             w_hit;
    logic             w_match_any;
    logic             w_pulse;
    logic [IDX_W-1:0] w_target;
    logic             w_lookup_in_range;
    logic [IDX_W-1:0] w_lookup_idx;

    assign w_hit       = r_active[r_scan_idx] && (r_note[r_scan_idx] == r_note_num);
    assign w_match_any = r_match_found || w_hit;
    assign w_pulse     = r_note_on || r_match_found;
    assign w_target    = r_match_found ? r_match_idx :
                         r_free_found  ? r_free_idx  : r_oldest_idx;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_ready      = 1'b0;
        w_flag       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (bus.i_note_valid) begin
                    w_next_state = S_SCAN;
                end
            end
            S_SCAN: begin
                // A note-off that matched nothing has no work to issue.
                if (r_scan_idx == c_LAST_IDX) begin
                    w_next_state = (!r_note_on && !w_match_any) ? S_IDLE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_flag       = w_pulse;
                w_next_state = w_pulse ? S_DRAIN : S_IDLE;
            end
            S_DRAIN: begin
                if (bus.i_pipeline_state == c_PIPE_CLEAR) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_active[v] <= 1'b0;
                r_note[v]   <= 7'd0;
                r_age[v]    <= '0;
            end
            r_note_on     <= 1'b0;
            r_note_num    <= 7'd0;
            r_scan_idx    <= '0;
            r_match_found <= 1'b0;
            r_match_idx   <= '0;
            r_free_found  <= 1'b0;
            r_free_idx    <= '0;
            r_oldest_idx  <= '0;
            r_oldest_age  <= '0;
            r_hold_status <= 1'b0;
            r_hold_index  <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.i_note_valid) begin
                        r_note_on     <= bus.i_note_on;
                        r_note_num    <= bus.i_note_num;
                        r_scan_idx    <= '0;
                        r_match_found <= 1'b0;
                        r_match_idx   <= '0;
                        r_free_found  <= 1'b0;
                        r_free_idx    <= '0;
                        r_oldest_idx  <= '0;
                        r_oldest_age  <= '0;
                    end
                end
                S_SCAN: begin
                    if (w_hit && !r_match_found) begin
                        r_match_found <= 1'b1;
                        r_match_idx   <= r_scan_idx;
                    end
                    if (!r_active[r_scan_idx] && !r_free_found) begin
                        r_free_found <= 1'b1;
                        r_free_idx   <= r_scan_idx;
                    end
                    // Strictly greater keeps ties on the lowest index.
                    if (r_age[r_scan_idx] > r_oldest_age) begin
                        r_oldest_idx <= r_scan_idx;
                        r_oldest_age <= r_age[r_scan_idx];
                    end
                    if (r_scan_idx != c_LAST_IDX) begin
                        r_scan_idx <= r_scan_idx + 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (r_note_on) begin
                        for (int v = 0; v < NUM_VOICES; v++) begin
                            if (w_target == IDX_W'(v)) begin
                                r_active[v] <= 1'b1;
                                r_note[v]   <= r_note_num;
                                r_age[v]    <= '0;
                            end else if (r_age[v] != '1) begin
                                r_age[v] <= r_age[v] + 1'b1;
                            end
                        end
                        r_hold_status <= 1'b1;
                        r_hold_index  <= 8'(w_target);
                    end else if (r_match_found) begin
                        r_active[r_match_idx] <= 1'b0;
                        r_hold_status         <= 1'b0;
                        r_hold_index          <= 8'(r_match_idx);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Update fields are live during the issue cycle and hold afterwards.
    assign bus.o_note_ready      = w_ready;
    assign bus.o_upd_flag        = w_flag;
    assign bus.o_upd_note_status = w_flag ? r_note_on : r_hold_status;
    assign bus.o_upd_voice_index = w_flag ? 8'(w_target) : r_hold_index;

    assign w_lookup_in_range   = ({1'b0, bus.i_lookup_voice} < c_NUM_VOICES_9);
    assign w_lookup_idx        = bus.i_lookup_voice[IDX_W-1:0];
    assign bus.o_lookup_active = w_lookup_in_range && r_active[w_lookup_idx];
    assign bus.o_lookup_note   = w_lookup_in_range ? r_note[w_lookup_idx] : 7'd0;

endmodule
`default_nettype wire

// File: tb/tb_voice_allocator.sv
`default_nettype none
// ============================================================================
// Module   : tb_voice_allocator
// Brief    : Scoreboard bench for voice_allocator update pulses and lookups.
// Revision : 1.0
// ============================================================================
module tb_voice_allocator;

    localparam int NV = 8;

    typedef struct packed {
        logic        status;
        logic [7:0]  voice;
        logic [31:0] cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [31:0] cyc = 0;
    exp_t        sb[$];
    exp_t        mon_e;
    logic        prev_flag = 1'b0;
    logic        ps_manual = 1'b0;
    logic [1:0]  ps_value = 2'd0;
    logic [1:0]  ps_cnt = 2'd0;

    always #5 clk = ~clk;

    voice_allocator_if bus();

    voice_allocator #(.NUM_VOICES(NV), .AGE_W(8)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Free-running ADSR phase unless a test pins it.
    initial begin
        bus.i_pipeline_state = 2'd0;
        forever begin
            @(posedge clk);
            #1;
            ps_cnt = ps_cnt + 2'd1;
            bus.i_pipeline_state = ps_manual ? ps_value : ps_cnt;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_flag = 1'b0;
        end else begin
            if (bus.o_upd_flag) begin
                check("flag_back_to_back", {31'd0, prev_flag}, 0);
                if (sb.size() == 0) begin
                    check("unexpected_flag", {31'd0, bus.o_upd_flag}, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("upd_status", {31'd0, bus.o_upd_note_status}, {31'd0, mon_e.status});
                    check("upd_voice", {24'd0, bus.o_upd_voice_index}, {24'd0, mon_e.voice});
                    check("flag_cycle", cyc, mon_e.cyc);
                end
            end
            prev_flag = bus.o_upd_flag;
        end
    end

    task automatic wait_ready(input string tag);
        int n = 0;
        @(negedge clk);
        while (!bus.o_note_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.o_note_ready) check(tag, {31'd0, bus.o_note_ready}, 1);
    endtask

    task automatic send_note(input logic on, input logic [6:0] num, input logic exp_flag,
                             input logic [7:0] exp_voice, input logic wait_done,
                             output logic [31:0] acc);
        exp_t e;
        wait_ready("accept_timeout");
        bus.i_note_valid = 1'b1;
        bus.i_note_on    = on;
        bus.i_note_num   = num;
        @(posedge clk);
        #1;
        acc = cyc;
        bus.i_note_valid = 1'b0;
        if (exp_flag) begin
            e.status = on;
            e.voice  = exp_voice;
            e.cyc    = acc + NV;
            sb.push_back(e);
        end
        if (wait_done) begin
            wait_ready("done_timeout");
            check("flag_seen", sb.size(), 0);
        end
    endtask

    task automatic lookup(input logic [7:0] v, input logic [6:0] en, input logic ea);
        bus.i_lookup_voice = v;
        #1;
        check($sformatf("lookup_note_v%0d", v), {25'd0, bus.o_lookup_note}, {25'd0, en});
        check($sformatf("lookup_active_v%0d", v), {31'd0, bus.o_lookup_active}, {31'd0, ea});
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        bus.i_note_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] acc;
        logic [31:0] c;
        int unsigned cnt;
        int          n;

        rst_n              = 1'b0;
        bus.i_note_valid   = 1'b0;
        bus.i_note_on      = 1'b0;
        bus.i_note_num     = 7'd0;
        bus.i_lookup_voice = 8'd0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_flag", {31'd0, bus.o_upd_flag}, 0);
        check("rst_status", {31'd0, bus.o_upd_note_status}, 0);
        check("rst_index", {24'd0, bus.o_upd_voice_index}, 0);
        lookup(8'd0, 7'd0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", {31'd0, bus.o_note_ready}, 1);

        // Single note-on
        send_note(1'b1, 7'd60, 1'b1, 8'd0, 1'b1, acc);
        lookup(8'd0, 7'd60, 1'b1);

        // Note-off frees a voice which is then reused
        do_reset();
        send_note(1'b1, 7'd60, 1'b1, 8'd0, 1'b1, acc);
        send_note(1'b1, 7'd62, 1'b1, 8'd1, 1'b1, acc);
        send_note(1'b1, 7'd64, 1'b1, 8'd2, 1'b1, acc);
        send_note(1'b0, 7'd62, 1'b1, 8'd1, 1'b1, acc);
        lookup(8'd1, 7'd62, 1'b0);
        send_note(1'b1, 7'd70, 1'b1, 8'd1, 1'b1, acc);
        lookup(8'd1, 7'd70, 1'b1);

        // Fill all voices, then steal oldest twice
        do_reset();
        for (int i = 0; i < NV; i++) begin
            send_note(1'b1, 7'(40 + i), 1'b1, 8'(i), 1'b1, acc);
        end
        send_note(1'b1, 7'd50, 1'b1, 8'd0, 1'b1, acc);
        lookup(8'd0, 7'd50, 1'b1);
        lookup(8'd7, 7'd47, 1'b1);
        send_note(1'b1, 7'd51, 1'b1, 8'd1, 1'b1, acc);
        lookup(8'd1, 7'd51, 1'b1);

        // Same-note retrigger
        do_reset();
        send_note(1'b1, 7'd60, 1'b1, 8'd0, 1'b1, acc);
        send_note(1'b1, 7'd60, 1'b1, 8'd0, 1'b1, acc);
        lookup(8'd1, 7'd0, 1'b0);
        lookup(8'd0, 7'd60, 1'b1);

        // Note-off with no match: no pulse, ready after the scan
        do_reset();
        send_note(1'b0, 7'd99, 1'b0, 8'd0, 1'b0, acc);
        n = 0;
        @(negedge clk);
        while (!bus.o_note_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("nomatch_ready_cycle", cyc, acc + NV);

        // Drain stalls until pipeline phase 2 is seen
        do_reset();
        ps_manual = 1'b1;
        ps_value  = 2'd0;
        send_note(1'b1, 7'd60, 1'b1, 8'd0, 1'b0, acc);
        cnt = 0;
        repeat (NV + 21) begin
            @(negedge clk);
            if (bus.o_note_ready) cnt++;
        end
        check("stall_ready_count", cnt, 0);
        check("stall_flag_seen", sb.size(), 0);
        ps_value = 2'd2;
        @(posedge clk);
        #2;
        c = cyc;
        n = 0;
        @(negedge clk);
        while (!bus.o_note_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_release_cycle", cyc, c + 1);
        ps_manual = 1'b0;

        // Reset during scan abandons the event
        do_reset();
        send_note(1'b1, 7'd60, 1'b0, 8'd0, 1'b0, acc);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (NV + 6) @(negedge clk);
        cnt = 0;
        for (int v = 0; v < NV; v++) begin
            bus.i_lookup_voice = 8'(v);
            #1;
            if (bus.o_lookup_active) cnt++;
        end
        check("rst_scan_active_count", cnt, 0);
        check("rst_scan_ready", {31'd0, bus.o_note_ready}, 1);

        // Out-of-range lookups read inactive
        send_note(1'b1, 7'd33, 1'b1, 8'd0, 1'b1, acc);
        lookup(8'd0, 7'd33, 1'b1);
        lookup(8'd8, 7'd0, 1'b0);
        lookup(8'd200, 7'd0, 1'b0);

        repeat (4) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Sits between the MIDI note-event decoder and the ADSR envelope block.
- Maps incoming note-on/note-off events onto NUM_VOICES voice slots, using free-voice allocation, same-note retrigger and oldest-voice stealing.
- Issues one keystate update at a time on the ADSR update interface (flag / note status / voice index).
- Paces updates so the ADSR's single-entry update buffer is never overrun; it uses the ADSR pipeline_state to know when that buffer has been drained.

Parameters:
- NUM_VOICES, 8, number of voice slots. Range 1..256.
- AGE_W, 8, width of the per-voice saturating age counter.

Ports:
- i_clk  in  1  system clock.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_note_valid  in  1  note event present.
- i_note_on  in  1  1 = note-on, 0 = note-off.
- i_note_num  in  7  MIDI note number.
- o_note_ready  out  1  allocator can accept an event; transfer occurs when i_note_valid & o_note_ready.
- i_pipeline_state  in  2  ADSR pipeline phase (same signal that drives the ADSR).
- o_upd_flag  out  1  one-cycle pulse: update valid (drives ADSR SPI_flag).
- o_upd_note_status  out  1  keystate to write (drives ADSR SPI_note_status).
- o_upd_voice_index  out  8  target voice (drives ADSR SPI_voice_index).
- i_lookup_voice  in  8  voice index for the note lookup port.
- o_lookup_note  out  7  note held by i_lookup_voice; combinational.
- o_lookup_active  out  1  voice i_lookup_voice is key-down; combinational. Reads 0 when the index is >= NUM_VOICES.

Behaviour:
- Per-voice state: active (1b), note (7b), age (AGE_W, saturating).
- Reset (asynchronous, i_reset_n=0):
  - All voices inactive, note=0, age=0.
  - o_upd_flag=0, o_upd_note_status=0, o_upd_voice_index=0.
  - FSM to IDLE; o_note_ready=1 from the first clock edge after release.
  - Reset mid-operation abandons any pending event silently; no update is issued.
- FSM states: IDLE, SCAN, ISSUE, DRAIN.
- IDLE:
  - o_note_ready=1.
  - On valid&ready: latch note_on and note_num, clear the scan registers, go to SCAN.
  - o_note_ready is 0 in every other state; events presented then are not accepted and stay pending at the source.
- SCAN:
  - Visits voice v = 0..NUM_VOICES-1, one per cycle, taking exactly NUM_VOICES cycles.
  - Tracked results:
    - match = first v with active & note==note_num.
    - free = first v with !active.
    - oldest = v with the largest age; ties go to the lowest index; inactive voices included.
  - Then go to ISSUE.
- ISSUE (one cycle):
  - Note-on target = match if found, else free if found, else oldest (steal).
    - Target: active<=1, note<=note_num, age<=0.
    - Every other voice: age+1, saturating at all-ones.
    - Pulse o_upd_flag with note_status=1, voice_index=target.
  - Note-off with match found:
    - Matched voice: active<=0, note unchanged.
    - Ages unchanged.
    - Pulse o_upd_flag with note_status=0, voice_index=match.
  - Note-off with no match: no flag pulse; go straight to IDLE.
  - After a pulse, go to DRAIN.
- DRAIN:
  - Wait until i_pipeline_state==2 is sampled, then one further cycle, then IDLE.
  - This guarantees the ADSR has consumed and cleared its buffered update before the next pulse.
  - i_pipeline_state==2 in the cycle right after ISSUE counts.
- Invariants:
  - A given note is held by at most one active voice.
  - o_upd_flag is never high in two consecutive cycles, and never high outside ISSUE.
- Latency:
  - Accept at cycle t; flag at t+NUM_VOICES+1.
  - Ready again at least 2 cycles after the flag.
- o_upd_note_status and o_upd_voice_index hold their last values between pulses.

Test Plan:
- Reset, then note-on 60 → flag pulse at accept+9 (NUM_VOICES=8), status=1, voice=0. Lookup voice 0 → note 60, active 1.
- Note-on 60,62,64 then note-off 62 → three note-ons go to voices 0,1,2. Note-off gives flag with status=0, voice=1; lookup voice 1 active=0. Next note-on 70 goes to voice 1.
- 8 note-ons (notes 40..47), then note-on 50 → 50 steals voice 0 (oldest, age 7) with status=1. Voice 0 note=50; voices 1..7 ages incremented.
- Note-on 60 twice → second event retriggers voice 0 (flag, status=1, voice=0); voice 1 stays inactive.
- Note-off 99 never played → no flag pulse; o_note_ready returns high at accept+9.
- Hold i_pipeline_state≠2 for 20 cycles after the flag → o_note_ready stays 0 and no second flag appears. Once state 2 is seen, ready rises 1 cycle later. Asserting i_reset_n=0 during SCAN → no flag, and all voices read inactive.
